// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: cpu/fpu request ports, unified memory port and debug status of the arbiter (master = arbiter side, slave = environment side)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                cpu_valid;
    logic                cpu_instr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W/8-1:0] cpu_wstrb;
    logic                cpu_ready;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                fpu_valid;
    logic [ADDR_W-1:0]   fpu_addr;
    logic [DATA_W-1:0]   fpu_wdata;
    logic [DATA_W/8-1:0] fpu_wstrb;
    logic                fpu_ready;
    logic [DATA_W-1:0]   fpu_rdata;
    logic                mem_valid;
    logic                mem_instr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic [1:0]          grant;
    logic                timeout_err;
    modport master (
        input  cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_ready, cpu_rdata,
        input  fpu_valid, fpu_addr, fpu_wdata, fpu_wstrb,
        output fpu_ready, fpu_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output grant, timeout_err
    );
    modport slave (
        output cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_ready, cpu_rdata,
        output fpu_valid, fpu_addr, fpu_wdata, fpu_wstrb,
        input  fpu_ready, fpu_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  grant, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered round-robin cpu/fpu arbiter onto one memory port with watchdog abort; ports clk, reset (async high), bus (mem_port_arbiter_if.master)
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ABORT_DATA = 32'hDEAD_BEEF
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = DATA_W / 8;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_n;
    logic last_fpu, last_fpu_n, pick_fpu, expired;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] grant_n;
    logic mem_valid_n, mem_instr_n, cpu_ready_n, fpu_ready_n, timeout_err_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, cpu_rdata_n, fpu_rdata_n, resp_data;
    logic [SW-1:0] mem_wstrb_n;
    always_comb begin
        pick_fpu = bus.fpu_valid & (~bus.cpu_valid | ~last_fpu);
        expired = ~bus.mem_ready & (cnt == LAST);
        resp_data = bus.mem_ready ? bus.mem_rdata : ABORT_DATA;
        state_n = state;
        last_fpu_n = last_fpu;
        cnt_n = cnt;
        grant_n = bus.grant;
        mem_valid_n = bus.mem_valid;
        mem_instr_n = bus.mem_instr;
        mem_addr_n = bus.mem_addr;
        mem_wdata_n = bus.mem_wdata;
        mem_wstrb_n = bus.mem_wstrb;
        cpu_ready_n = 1'b0;
        fpu_ready_n = 1'b0;
        cpu_rdata_n = bus.cpu_rdata;
        fpu_rdata_n = bus.fpu_rdata;
        timeout_err_n = bus.timeout_err;
        case (state)
            IDLE: if (bus.cpu_valid | bus.fpu_valid) begin
                state_n = BUSY;
                last_fpu_n = pick_fpu;
                cnt_n = '0;
                grant_n = pick_fpu ? 2'b10 : 2'b01;
                mem_valid_n = 1'b1;
                mem_instr_n = ~pick_fpu & bus.cpu_instr;
                mem_addr_n = pick_fpu ? bus.fpu_addr : bus.cpu_addr;
                mem_wdata_n = pick_fpu ? bus.fpu_wdata : bus.cpu_wdata;
                mem_wstrb_n = pick_fpu ? bus.fpu_wstrb : bus.cpu_wstrb;
            end
            // last_fpu already names the master that owns this transfer
            BUSY: if (bus.mem_ready | expired) begin
                state_n = RESP;
                mem_valid_n = 1'b0;
                cpu_ready_n = ~last_fpu;
                fpu_ready_n = last_fpu;
                cpu_rdata_n = last_fpu ? bus.cpu_rdata : resp_data;
                fpu_rdata_n = last_fpu ? resp_data : bus.fpu_rdata;
                timeout_err_n = bus.timeout_err | expired;
            end else begin
                cnt_n = cnt + CW'(cnt != '1);
            end
            RESP: begin
                state_n = IDLE;
                grant_n = 2'b00;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last_fpu <= 1'b1;
            cnt <= '0;
            bus.grant <= 2'b00;
            bus.mem_valid <= 1'b0;
            bus.mem_instr <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.cpu_ready <= 1'b0;
            bus.fpu_ready <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.fpu_rdata <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            last_fpu <= last_fpu_n;
            cnt <= cnt_n;
            bus.grant <= grant_n;
            bus.mem_valid <= mem_valid_n;
            bus.mem_instr <= mem_instr_n;
            bus.mem_addr <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
            bus.mem_wstrb <= mem_wstrb_n;
            bus.cpu_ready <= cpu_ready_n;
            bus.fpu_ready <= fpu_ready_n;
            bus.cpu_rdata <= cpu_rdata_n;
            bus.fpu_rdata <= fpu_rdata_n;
            bus.timeout_err <= timeout_err_n;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
    localparam int TO = 8;
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ABORT_DATA(ABORT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    int n_checks = 0;
    int n_fail = 0;
    logic m_last_fpu;
    logic [31:0] m_rdata [2];
    logic m_err;

    task automatic set_req(input bit c, input bit f);
        bus.cpu_valid = c;
        bus.fpu_valid = f;
        bus.cpu_instr = 1'($urandom);
        bus.cpu_addr = $urandom;
        bus.cpu_wdata = $urandom;
        bus.cpu_wstrb = 4'($urandom);
        bus.fpu_addr = $urandom;
        bus.fpu_wdata = $urandom;
        bus.fpu_wstrb = 4'($urandom);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        set_req(0, 0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_last_fpu = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_err = 1'b0;
    endtask

    // Runs one arbitration from the IDLE negedge with valids already driven;
    // lat = BUSY cycle on which memory answers (0 or >TO: never).
    task automatic do_txn(input int lat, input logic [31:0] rd, input bit drop, output logic [1:0] g);
        bit f;
        logic [31:0] a, wd, exp_rd;
        logic [3:0] ws;
        logic ins;
        logic [1:0] exp_g;
        int busy, exp_busy;
        bit ok;
        f = bus.fpu_valid && (!bus.cpu_valid || !m_last_fpu);
        a = f ? bus.fpu_addr : bus.cpu_addr;
        wd = f ? bus.fpu_wdata : bus.cpu_wdata;
        ws = f ? bus.fpu_wstrb : bus.cpu_wstrb;
        ins = !f && bus.cpu_instr;
        exp_g = f ? 2'b10 : 2'b01;
        ok = lat >= 1 && lat <= TO;
        exp_busy = ok ? lat : TO;
        exp_rd = ok ? rd : ABORT;
        busy = 0;
        g = 2'b00;
        @(negedge clk);
        while (bus.mem_valid === 1'b1 && busy < 2 * TO) begin
            busy++;
            if (busy == 1) g = bus.grant;
            n_checks++;
            if (bus.grant !== exp_g) begin
                n_fail++;
                $display("FAIL grant busy%0d: got %b want %b", busy, bus.grant, exp_g);
            end
            n_checks++;
            if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_instr} !== {a, wd, ws, ins}) begin
                n_fail++;
                $display("FAIL mem_bus busy%0d: got %h/%h/%h/%b want %h/%h/%h/%b", busy,
                         bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_instr, a, wd, ws, ins);
            end
            n_checks++;
            if ({bus.cpu_ready, bus.fpu_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL ready_in_busy busy%0d: got %b want 00", busy, {bus.cpu_ready, bus.fpu_ready});
            end
            set_req(bus.cpu_valid, bus.fpu_valid);
            bus.mem_ready = (busy == lat);
            bus.mem_rdata = (busy == lat) ? rd : $urandom;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        m_rdata[f] = exp_rd;
        m_err = m_err | !ok;
        m_last_fpu = f;
        n_checks++;
        if (busy != exp_busy) begin
            n_fail++;
            $display("FAIL busy_cycles: got %0d want %0d", busy, exp_busy);
        end
        n_checks++;
        if ({bus.cpu_ready, bus.fpu_ready, bus.grant, bus.mem_valid} !== {!f, f, exp_g, 1'b0}) begin
            n_fail++;
            $display("FAIL resp_pulse: got rdy=%b grant=%b mv=%b want rdy=%b grant=%b mv=0",
                     {bus.cpu_ready, bus.fpu_ready}, bus.grant, bus.mem_valid, {!f, f}, exp_g);
        end
        n_checks++;
        if ({bus.cpu_rdata, bus.fpu_rdata, bus.timeout_err} !== {m_rdata[0], m_rdata[1], m_err}) begin
            n_fail++;
            $display("FAIL resp_data: got %h/%h err=%b want %h/%h err=%b",
                     bus.cpu_rdata, bus.fpu_rdata, bus.timeout_err, m_rdata[0], m_rdata[1], m_err);
        end
        if (drop) begin
            if (f) bus.fpu_valid = 1'b0;
            else bus.cpu_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_ready, bus.fpu_ready, bus.grant, bus.mem_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: got rdy=%b grant=%b mv=%b want all 0",
                     {bus.cpu_ready, bus.fpu_ready}, bus.grant, bus.mem_valid);
        end
        n_checks++;
        if ({bus.cpu_rdata, bus.fpu_rdata} !== {m_rdata[0], m_rdata[1]}) begin
            n_fail++;
            $display("FAIL rdata_hold: got %h/%h want %h/%h", bus.cpu_rdata, bus.fpu_rdata, m_rdata[0], m_rdata[1]);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.cpu_ready, bus.cpu_rdata, bus.fpu_ready, bus.fpu_rdata, bus.mem_valid, bus.mem_instr,
             bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.grant, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mv=%b grant=%b rd=%h/%h err=%b want all 0",
                     bus.mem_valid, bus.grant, bus.cpu_rdata, bus.fpu_rdata, bus.timeout_err);
        end
    endtask

    task automatic test_cpu_read();
        logic [1:0] g;
        set_req(1, 0);
        bus.cpu_instr = 1'b1;
        bus.cpu_addr = 32'h10;
        bus.cpu_wstrb = 4'h0;
        do_txn(2, 32'h1234_5678, 1, g);
        n_checks++;
        if (bus.cpu_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL cpu_read_data: got %h want 12345678", bus.cpu_rdata);
        end
    endtask

    task automatic test_fpu_write();
        logic [1:0] g;
        set_req(0, 1);
        bus.fpu_addr = 32'h2000;
        bus.fpu_wdata = 32'h3F80_0000;
        bus.fpu_wstrb = 4'hF;
        do_txn(1, $urandom, 1, g);
        n_checks++;
        if (g !== 2'b10) begin
            n_fail++;
            $display("FAIL fpu_write_grant: got %b want 10", g);
        end
    endtask

    task automatic test_contention();
        logic [1:0] g;
        logic [1:0] want;
        set_req(1, 1);
        for (int i = 0; i < 4; i++) begin
            do_txn(1, $urandom, 0, g);
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (g !== want) begin
                n_fail++;
                $display("FAIL contention_seq%0d: got %b want %b", i, g, want);
            end
        end
        set_req(0, 0);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        set_req(1, 0);
        bus.cpu_wstrb = 4'h0;
        do_txn(0, 32'h0, 1, g);
        n_checks++;
        if ({bus.cpu_rdata, bus.timeout_err} !== {ABORT, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_abort: got %h err=%b want deadbeef err=1", bus.cpu_rdata, bus.timeout_err);
        end
        set_req(0, 1);
        do_txn(3, $urandom, 1, g);
        set_req(1, 0);
        do_txn(1, $urandom, 1, g);
        n_checks++;
        if (bus.timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b want 1", bus.timeout_err);
        end
    endtask

    task automatic test_timeout_boundary();
        logic [1:0] g;
        apply_reset();
        set_req(1, 0);
        do_txn(TO, 32'hA5A5_0001, 1, g);
        set_req(0, 1);
        do_txn(TO - 1, 32'hA5A5_0002, 1, g);
        n_checks++;
        if ({bus.cpu_rdata, bus.fpu_rdata, bus.timeout_err} !== {32'hA5A5_0001, 32'hA5A5_0002, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_boundary: got %h/%h err=%b want a5a50001/a5a50002 err=0",
                     bus.cpu_rdata, bus.fpu_rdata, bus.timeout_err);
        end
    endtask

    task automatic test_random();
        logic [1:0] g;
        logic [1:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 2'($urandom_range(1, 3));
            set_req(v[0], v[1]);
            do_txn($urandom_range(1, TO + 2), $urandom, 1'($urandom), g);
        end
        set_req(0, 0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        logic [1:0] g;
        set_req(0, 1);
        @(negedge clk);
        n_checks++;
        if ({bus.mem_valid, bus.grant} !== 3'b110) begin
            n_fail++;
            $display("FAIL pre_reset_busy: got mv=%b grant=%b want mv=1 grant=10", bus.mem_valid, bus.grant);
        end
        bus.mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_valid, bus.grant, bus.fpu_ready, bus.timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got mv=%b grant=%b frdy=%b err=%b want all 0",
                     bus.mem_valid, bus.grant, bus.fpu_ready, bus.timeout_err);
        end
        set_req(1, 1);
        @(negedge clk);
        n_checks++;
        if ({bus.fpu_ready, bus.cpu_ready, bus.fpu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL no_pulse_after_reset: got rdy=%b frd=%h want 0", {bus.cpu_ready, bus.fpu_ready}, bus.fpu_rdata);
        end
        reset = 1'b0;
        m_last_fpu = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_err = 1'b0;
        do_txn(1, $urandom, 1, g);
        n_checks++;
        if (g !== 2'b01) begin
            n_fail++;
            $display("FAIL first_tie_after_reset: got %b want 01", g);
        end
        set_req(0, 0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_fpu_write();
        test_contention();
        test_timeout();
        test_timeout_boundary();
        test_random();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Registered two-master memory arbiter between the picorv32 core and the SRFPU on one side and the unified (von Neumann) memory on the other.
- Replaces the combinational valid-priority mux with a request-latching FSM:
  - round-robin fairness on simultaneous requests;
  - one outstanding transaction at a time;
  - watchdog timeout that aborts hung transfers and flags the error.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 64, max cycles mem_valid may stay high without mem_ready before abort (must be >= 2)
- ABORT_DATA, 32'hDEAD_BEEF, rdata returned to the master on timeout

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_valid  in  1  core request
- cpu_instr  in  1  core request is instruction fetch
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_wstrb  in  DATA_W/8  core byte strobes, 0 = read
- cpu_ready  out  1  one-cycle completion pulse to core
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- fpu_valid  in  1  FPU request
- fpu_addr  in  ADDR_W  FPU address
- fpu_wdata  in  DATA_W  FPU write data
- fpu_wstrb  in  DATA_W/8  FPU byte strobes, 0 = read
- fpu_ready  out  1  one-cycle completion pulse to FPU
- fpu_rdata  out  DATA_W  read data, valid while fpu_ready=1
- mem_valid  out  1  request to memory
- mem_instr  out  1  forwarded cpu_instr; 0 for FPU grants
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_wstrb  out  DATA_W/8  latched strobes
- mem_ready  in  1  memory completion
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- grant  out  2  debug: 2'b00 none, 2'b01 cpu, 2'b10 fpu
- timeout_err  out  1  sticky, set on any abort, cleared only by reset

Behaviour:
- Reset (async, active-high) forces:
  - FSM to IDLE;
  - all outputs to 0, including rdata buses and timeout_err;
  - last_grant to FPU, so the first tie goes to the CPU.
- Reset mid-transaction drops mem_valid immediately. No ready pulse is issued for the killed transfer.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Neither valid: stay.
  - One valid: grant that master.
  - Both valid: grant the master not equal to last_grant.
  - On grant, at the same edge:
    - latch addr/wdata/wstrb/instr into mem_* registers;
    - set mem_valid=1, set grant, update last_grant;
    - clear the timeout counter;
    - go to BUSY.
- BUSY:
  - mem_valid held at 1 and mem_* outputs stable until exit.
  - Requester inputs are ignored after latching.
  - Exit on mem_ready=1:
    - capture mem_rdata into the granted master's rdata register;
    - assert that master's ready, set mem_valid=0;
    - go to RESP.
  - Exit on timeout (counter reaches TIMEOUT_CYCLES-1 with mem_ready=0):
    - load ABORT_DATA into the master's rdata;
    - assert its ready, set timeout_err=1, set mem_valid=0;
    - go to RESP.
  - mem_ready on the timeout cycle wins: normal completion, no error.
- RESP:
  - The ready pulse is exactly one cycle.
  - Next edge: clear the ready, set grant=0, go to IDLE.
  - Requests are not sampled in RESP, because the master is still deasserting the completed valid.
- Latency: request first seen in IDLE at cycle 0 → mem_valid at 1 → mem_ready at k≥1 → master ready at k+1 → IDLE at k+2.
- A master whose valid is held continuously receives a new grant no earlier than cycle k+2.
- The non-granted master's ready stays 0 throughout. Its rdata holds its previous value.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide, increments each BUSY cycle and saturates.
- No combinational path from any input to any output.

Test Plan:
- Single CPU read:
  - Stimulus: reset, then cpu_valid=1, addr=0x10, wstrb=0; memory returns 0x12345678 with mem_ready at cycle 2.
  - Required: mem_valid at cycle 1 with mem_addr=0x10 and mem_instr echoed; cpu_ready=1 at cycle 3 with cpu_rdata=0x12345678; fpu_ready never asserted.
- FPU write:
  - Stimulus: fpu_valid=1, addr=0x2000, wdata=0x3F800000, wstrb=4'hF.
  - Required: mem_wstrb=4'hF, mem_instr=0; fpu_ready one-cycle pulse one cycle after mem_ready; grant=2'b10 during BUSY.
- Contention:
  - Stimulus: both valid every cycle after reset, memory with 1-cycle ready.
  - Required: grant sequence 01,10,01,10; each master served every other transaction; no cycle with both readys high.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, cpu read, mem_ready held 0.
  - Required: mem_valid high exactly 8 cycles; cpu_ready pulse with cpu_rdata=0xDEADBEEF; timeout_err=1 and stays 1 across later successful transfers.
- Timeout boundary:
  - Stimulus: mem_ready asserted on the 8th BUSY cycle (TIMEOUT_CYCLES=8).
  - Required: normal completion with mem_rdata returned; timeout_err stays 0.
- Reset mid-BUSY:
  - Stimulus: assert reset asynchronously between clock edges during an FPU read.
  - Required: mem_valid, grant and fpu_ready drop immediately with no ready pulse; after release, a simultaneous request is granted to the CPU first.
